prog_rom_responder: RTL and testbench

Host-loadable instruction store that answers the TPU's external program-fetch interface. It holds the program words that the TPU fetches through its request output and 7-bit address output. It returns each word with a single-cycle ready pulse after a fixed, parameterised latency. It also drives the TPU's `i_REB` run-enable, keeping the core halted until the host has finished loading the program.

---
 rtl/prog_rom_responder_if.sv | 33 +++
 rtl/prog_rom_responder.sv | 182 ++++++++++++++++++
 tb/tb_prog_rom_responder.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_rom_responder_if.sv
// prog_rom_responder_if
// ---------------------
// Fetch bus between the TPU (master) and the program store (slave).
// The master drives a request and an address. The slave returns the word,
// a one-cycle ready pulse, and a busy flag.
//
// Signals:
//   rd_rqst  master->slave  fetch request (TPU o_RD_RQST)
//   addr     master->slave  fetch address (TPU o_ADDR)
//   rdata    slave->master  fetched instruction word (o_DO)
//   ready    slave->master  one-cycle pulse, rdata valid (o_READY)
//   busy     slave->master  fetch in flight (o_BUSY)
//   perr     slave->master  parity error pulse (o_PERR), present only
//                           when PROG_ROM_PARITY_EN is defined
interface prog_rom_responder_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
);
  logic              rd_rqst;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;
`ifdef PROG_ROM_PARITY_EN
  logic              perr;

  modport master (output rd_rqst, addr, input rdata, ready, busy, perr);
  modport slave  (input rd_rqst, addr, output rdata, ready, busy, perr);
`else
  modport master (output rd_rqst, addr, input rdata, ready, busy);
  modport slave  (input rd_rqst, addr, output rdata, ready, busy);
`endif
endinterface

// File: rtl/prog_rom_responder.sv
// prog_rom_responder
// ------------------
// This is a host-loadable instruction store that answers the TPU
// program-fetch interface. Each fetch is answered with a single-cycle ready
// pulse, RD_LATENCY cycles after the request is accepted. The block also
// drives the TPU run-enable o_REB (active low). o_REB holds the core halted
// while the host loads the program.
//
// Ports:
//   i_SCLK        clock, rising edge
//   i_RESET       synchronous active-high reset
//   i_LD_WE       host write strobe, honoured only in load mode (o_REB=1)
//   i_LD_ADDR     host write address
//   i_LD_DATA     host write data
//   i_LD_DONE     host pulse: load complete, release the TPU
//   i_LD_RESTART  host pulse: re-halt the TPU for reloading
//   o_REB         TPU run-enable, active low
//   fetch         slave side of prog_rom_responder_if
//                 (rd_rqst/addr in, rdata/ready/busy[/perr] out)
//
// Optional feature macro: PROG_ROM_PARITY_EN
//   When this macro is defined, each word stores an even-parity bit and
//   fetch.perr pulses with fetch.ready when the stored parity does not match
//   the word. A load write of all-ones data in the same cycle as i_LD_DONE
//   stores inverted parity, so that an error can be injected.
//
// DEPTH must equal 2**ADDR_W, so every address is in range.
module prog_rom_responder #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 128,
  parameter int RD_LATENCY = 2
) (
  input  logic                   i_SCLK,
  input  logic                   i_RESET,
  input  logic                   i_LD_WE,
  input  logic [ADDR_W-1:0]      i_LD_ADDR,
  input  logic [DATA_W-1:0]      i_LD_DATA,
  input  logic                   i_LD_DONE,
  input  logic                   i_LD_RESTART,
  output logic                   o_REB,
  prog_rom_responder_if.slave    fetch
);

  localparam logic [3:0] LAT_M1 = 4'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Program storage. Reset does not clear it, so a program survives a core reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] do_q, do_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              reb_q, reb_d;

  // Writes land only while the core is halted, so a running program cannot be
  // altered under the TPU.
  always_ff @(posedge i_SCLK) begin
    if (i_LD_WE && reb_q) begin
      mem_q[i_LD_ADDR] <= i_LD_DATA;
    end
  end

`ifdef PROG_ROM_PARITY_EN
  logic par_q [DEPTH];
  logic perr_q, perr_d;
  logic par_wr;

  // Even parity. The all-ones-with-done combination flips the stored bit so
  // that the bench can inject an error.
  assign par_wr = (^i_LD_DATA) ^ (i_LD_DONE && (&i_LD_DATA));

  always_ff @(posedge i_SCLK) begin
    if (i_LD_WE && reb_q) begin
      par_q[i_LD_ADDR] <= par_wr;
    end
  end

  assign fetch.perr = perr_q;
`endif

  // Next-state logic.
  // Outputs are derived from the next state, so ready and busy come from
  // flops and line up with the state the FSM is entering.
  // The word is read at the edge that enters RESP. With a latency of 1, that
  // edge is also the acceptance edge, so the address comes from addr_d rather
  // than from the captured copy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    do_d    = do_q;
    ready_d = 1'b0;
    busy_d  = 1'b0;
`ifdef PROG_ROM_PARITY_EN
    perr_d  = 1'b0;
`endif

    if (i_LD_RESTART) begin
      reb_d = 1'b1;
    end else if (i_LD_DONE) begin
      reb_d = 1'b0;
    end else begin
      reb_d = reb_q;
    end

    case (state_q)
      IDLE: begin
        if (fetch.rd_rqst && !reb_q) begin
          addr_d  = fetch.addr;
          cnt_d   = LAT_M1;
          state_d = (RD_LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == RESP && state_q != RESP) begin
      do_d = mem_q[addr_d];
`ifdef PROG_ROM_PARITY_EN
      perr_d = (^mem_q[addr_d]) != par_q[addr_d];
`endif
    end

    ready_d = (state_d == RESP);
    busy_d  = (state_d != IDLE);
  end

  // FSM and output registers. Reset overrides a fetch in flight.
  always_ff @(posedge i_SCLK) begin
    if (i_RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      do_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      reb_q   <= 1'b1;
`ifdef PROG_ROM_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      do_q    <= do_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      reb_q   <= reb_d;
`ifdef PROG_ROM_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign fetch.rdata = do_q;
  assign fetch.ready = ready_q;
  assign fetch.busy  = busy_q;
  assign o_REB       = reb_q;

endmodule

// File: tb/tb_prog_rom_responder.sv
// tb_prog_rom_responder
// ---------------------
// This bench drives two instances of prog_rom_responder that share the host
// load port and the reset. dut0 uses RD_LATENCY=2 and dut1 uses RD_LATENCY=1.
// The stimulus pushes expected responses, with their data and cycle, into
// per-DUT queues. It also pushes point-in-time status expectations into a
// check queue. A monitor on the falling edge pops and compares both queues.
// Any ready pulse that has no queued expectation counts as an error.
module tb_prog_rom_responder;

  localparam int AW = 7;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_done;
  logic          ld_restart;
  logic          reb0, reb1;
  int            cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  prog_rom_responder_if #(.ADDR_W(AW), .DATA_W(DW)) fif0 ();
  prog_rom_responder_if #(.ADDR_W(AW), .DATA_W(DW)) fif1 ();

  prog_rom_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(128), .RD_LATENCY(2)) dut0 (
    .i_SCLK       (clk),
    .i_RESET      (rst),
    .i_LD_WE      (ld_we),
    .i_LD_ADDR    (ld_addr),
    .i_LD_DATA    (ld_data),
    .i_LD_DONE    (ld_done),
    .i_LD_RESTART (ld_restart),
    .o_REB        (reb0),
    .fetch        (fif0)
  );

  prog_rom_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(128), .RD_LATENCY(1)) dut1 (
    .i_SCLK       (clk),
    .i_RESET      (rst),
    .i_LD_WE      (ld_we),
    .i_LD_ADDR    (ld_addr),
    .i_LD_DATA    (ld_data),
    .i_LD_DONE    (ld_done),
    .i_LD_RESTART (ld_restart),
    .o_REB        (reb1),
    .fetch        (fif1)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            cycle;
  } exp_t;

  typedef struct {
    string         name;
    int            sel;   // 0 reb, 1 ready, 2 busy, 3 rdata, 4 pending responses
    int            dut;
    logic [DW-1:0] val;
  } chk_t;

  exp_t exp_q [2][$];
  chk_t chk_q [$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Monitor: compare responses and status checks away from the active edge.
  always @(negedge clk) begin : monitor
    logic          rdy;
    logic [DW-1:0] dat;
    logic [DW-1:0] act;
    exp_t          e;
    chk_t          c;
    for (int k = 0; k < 2; k++) begin
      rdy = (k == 0) ? fif0.ready : fif1.ready;
      dat = (k == 0) ? fif0.rdata : fif1.rdata;
      if (rdy) begin
        if (exp_q[k].size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_ready dut%0d: READY=1 at cycle %0d, required no response", k, cyc);
        end else begin
          e = exp_q[k].pop_front();
          n_cmp++;
          if (dat !== e.data) begin
            n_fail++;
            $display("[TB] FAIL resp_data dut%0d: got 0x%04h, required 0x%04h", k, dat, e.data);
          end
          n_cmp++;
          if (cyc != e.cycle) begin
            n_fail++;
            $display("[TB] FAIL resp_cycle dut%0d: READY at cycle %0d, required cycle %0d", k, cyc, e.cycle);
          end
        end
      end
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      case (c.sel)
        0:       act = DW'((c.dut == 0) ? reb0 : reb1);
        1:       act = DW'((c.dut == 0) ? fif0.ready : fif1.ready);
        2:       act = DW'((c.dut == 0) ? fif0.busy : fif1.busy);
        3:       act = (c.dut == 0) ? fif0.rdata : fif1.rdata;
        default: act = DW'(exp_q[c.dut].size());
      endcase
      n_cmp++;
      if (act !== c.val) begin
        n_fail++;
        $display("[TB] FAIL %s dut%0d: got 0x%0h, required 0x%0h", c.name, c.dut, act, c.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_status(input string name, input int sel, input int dut, input logic [DW-1:0] val);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.dut  = dut;
    c.val  = val;
    chk_q.push_back(c);
  endtask

  task automatic expect_resp(input int dut, input logic [DW-1:0] data, input int lat);
    exp_t e;
    e.data  = data;
    e.cycle = cyc + lat;
    exp_q[dut].push_back(e);
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_we   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    ld_done = 1'b0; ld_restart = 1'b0;
    fif0.rd_rqst = 1'b0; fif0.addr = '0;
    fif1.rd_rqst = 1'b0; fif1.addr = '0;

    // Reset state
    tick(); tick();
    expect_status("rst_reb",   0, 0, 16'd1);
    expect_status("rst_ready", 1, 0, 16'd0);
    expect_status("rst_busy",  2, 0, 16'd0);
    expect_status("rst_do",    3, 0, 16'h0000);
    expect_status("rst_reb",   0, 1, 16'd1);
    expect_status("rst_do",    3, 1, 16'h0000);
    rst = 1'b0;

    // Program load
    load_word(7'h05, 16'hA5C3);
    load_word(7'h00, 16'h1111);
    load_word(7'h01, 16'h2222);
    load_word(7'h7F, 16'h7F7F);

    // Requests in load mode are held off
    fif0.rd_rqst = 1'b1; fif0.addr = 7'h05;
    tick(); tick();
    expect_status("ldmode_busy", 2, 0, 16'd0);
    tick();
    fif0.rd_rqst = 1'b0;

    // Release, then fetch 0x05 at latency 2 with an address change in WAIT
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    expect_status("release_reb", 0, 0, 16'd0);
    fif0.rd_rqst = 1'b1; fif0.addr = 7'h05;
    expect_resp(0, 16'hA5C3, 2);
    tick();
    fif0.addr = 7'h00;
    expect_status("wait_busy", 2, 0, 16'd1);
    tick();
    fif0.rd_rqst = 1'b0;
    tick(); tick();
    expect_status("do_hold",   3, 0, 16'hA5C3);
    expect_status("idle_busy", 2, 0, 16'd0);

    // Writes in run mode are ignored
    load_word(7'h05, 16'hDEAD);
    fif0.rd_rqst = 1'b1; fif0.addr = 7'h05;
    expect_resp(0, 16'hA5C3, 2);
    tick(); tick();
    fif0.rd_rqst = 1'b0;
    tick(); tick();

    // Back-to-back at latency 1: ready every 2nd cycle, top address included
    fif1.rd_rqst = 1'b1; fif1.addr = 7'h00;
    expect_resp(1, 16'h1111, 1);
    tick();
    fif1.addr = 7'h01;
    expect_resp(1, 16'h2222, 2);
    tick(); tick();
    fif1.addr = 7'h7F;
    expect_resp(1, 16'h7F7F, 2);
    tick(); tick();
    fif1.rd_rqst = 1'b0;
    tick(); tick();

    // Reset mid-fetch: no response, array survives
    fif0.rd_rqst = 1'b1; fif0.addr = 7'h05;
    tick();
    fif0.rd_rqst = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_status("midrst_reb",  0, 0, 16'd1);
    expect_status("midrst_busy", 2, 0, 16'd0);
    tick(); tick();
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    fif0.rd_rqst = 1'b1; fif0.addr = 7'h05;
    expect_resp(0, 16'hA5C3, 2);
    tick(); tick();
    fif0.rd_rqst = 1'b0;
    tick();

    // Restart mid-fetch: fetch completes, held request not re-accepted
    fif0.rd_rqst = 1'b1; fif0.addr = 7'h7F;
    expect_resp(0, 16'h7F7F, 2);
    tick();
    ld_restart = 1'b1;
    tick();
    ld_restart = 1'b0;
    expect_status("restart_reb", 0, 0, 16'd1);
    tick(); tick();
    expect_status("restart_busy", 2, 0, 16'd0);
    tick(); tick();
    fif0.rd_rqst = 1'b0;
    tick();

    // Simultaneous done and restart: restart wins, core stays halted
    ld_done = 1'b1; ld_restart = 1'b1;
    tick();
    ld_done = 1'b0; ld_restart = 1'b0;
    expect_status("both_reb", 0, 0, 16'd1);
    fif0.rd_rqst = 1'b1; fif0.addr = 7'h05;
    tick(); tick(); tick();
    expect_status("both_busy", 2, 0, 16'd0);
    fif0.rd_rqst = 1'b0;
    tick(); tick();

    // Every queued response must have arrived
    expect_status("pending_resp", 4, 0, 16'd0);
    expect_status("pending_resp", 4, 1, 16'd0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
